// File: rtl/axis_depacketizer_pkg.sv
// Shared definitions for the AXI4-Stream depacketizer: FSM encoding and
// output skid buffer depth.
package axis_depacketizer_pkg;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/axis_depacketizer_if.sv
// AXI4-Stream bundle. A beat transfers on a clock edge where tvalid and tready
// are both high; the source holds tdata/tlast stable while tvalid is high and
// tready is low, and never withdraws tvalid before the transfer.
interface axis_depacketizer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer: in_ready depends only on occupancy, so the
// upstream ready path is cut from out_ready.
module axis_skid_buffer
    import axis_depacketizer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             head_valid_q, head_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [1:0]       occ;
    logic             push, pop;

    assign occ       = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
    assign in_ready  = (occ != 2'(SKID_DEPTH));
    assign push      = in_valid & in_ready;
    assign pop       = head_valid_q & out_ready;
    assign out_valid = head_valid_q;
    assign out_data  = head_data_q;

    // Pop first so a simultaneous push lands in whichever slot is free after it.
    always_comb begin
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        head_data_d  = head_data_q;
        skid_data_d  = skid_data_q;
        if (pop) begin
            if (skid_valid_q) begin
                head_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                head_valid_d = 1'b0;
            end
        end
        if (push) begin
            if (!head_valid_d) begin
                head_valid_d = 1'b1;
                head_data_d  = in_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            head_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            head_data_q  <= head_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/axis_depacketizer.sv
// Checks framed packet lengths against cfg_data+1 beats, forwards payload as an
// unframed stream through a skid buffer and counts good/short/long packets.
module axis_depacketizer
    import axis_depacketizer_pkg::*;
#(
    parameter int    AXIS_TDATA_WIDTH = 32,
    parameter int    CNTR_WIDTH       = 32,
    parameter string SYNC_ON_RESET    = "TRUE"
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [CNTR_WIDTH-1:0] cfg_data,
    axis_depacketizer_if.slave    s_axis,
    axis_depacketizer_if.master   m_axis,
    output logic [CNTR_WIDTH-1:0] sts_good_cntr,
    output logic [CNTR_WIDTH-1:0] sts_short_cntr,
    output logic [CNTR_WIDTH-1:0] sts_long_cntr,
    output logic [1:0]            sts_state
);

    localparam state_t RESET_STATE = (SYNC_ON_RESET == "FALSE") ? ST_RUN : ST_SYNC;
    localparam logic [CNTR_WIDTH-1:0] ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [CNTR_WIDTH-1:0] cntr_q, cntr_d;
    logic [CNTR_WIDTH-1:0] len_q, len_d;
    logic [CNTR_WIDTH-1:0] good_q, good_d;
    logic [CNTR_WIDTH-1:0] short_q, short_d;
    logic [CNTR_WIDTH-1:0] long_q, long_d;
    logic                  en_q;
    logic [CNTR_WIDTH-1:0] len_eff;
    logic                  s_ready, beat, buf_in_valid, buf_in_ready;

    // en_q keeps tready low until the first edge after reset release.
    assign s_ready       = en_q & ((state_q == ST_RUN) ? buf_in_ready : 1'b1);
    assign beat          = s_axis.tvalid & s_ready;
    assign buf_in_valid  = s_axis.tvalid & en_q & (state_q == ST_RUN);
    assign len_eff       = (cntr_q == '0) ? cfg_data : len_q;
    assign s_axis.tready = s_ready;
    assign m_axis.tlast  = 1'b0;

    always_comb begin
        state_d = state_q;
        cntr_d  = cntr_q;
        len_d   = len_q;
        good_d  = good_q;
        short_d = short_q;
        long_d  = long_q;
        case (state_q)
            ST_SYNC, ST_DISCARD: begin
                if (beat && s_axis.tlast) begin
                    state_d = ST_RUN;
                    cntr_d  = '0;
                end
            end
            ST_RUN: begin
                if (beat) begin
                    if (cntr_q == '0) len_d = cfg_data;
                    if (s_axis.tlast) begin
                        if (cntr_q == len_eff) good_d  = good_q + ONE;
                        else                   short_d = short_q + ONE;
                        cntr_d = '0;
                    end else if (cntr_q == len_eff) begin
                        // Beat L is forwarded; the rest of the packet is dropped.
                        long_d  = long_q + ONE;
                        state_d = ST_DISCARD;
                        cntr_d  = '0;
                    end else begin
                        cntr_d = cntr_q + ONE;
                    end
                end
            end
            default: begin
                state_d = ST_SYNC;
                cntr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= RESET_STATE;
            cntr_q  <= '0;
            len_q   <= '0;
            good_q  <= '0;
            short_q <= '0;
            long_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cntr_q  <= cntr_d;
            len_q   <= len_d;
            good_q  <= good_d;
            short_q <= short_d;
            long_q  <= long_d;
            en_q    <= 1'b1;
        end
    end

    axis_skid_buffer #(.WIDTH(AXIS_TDATA_WIDTH)) u_skid (
        .clk       (aclk),
        .rst       (areset),
        .in_data   (s_axis.tdata),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .out_data  (m_axis.tdata),
        .out_valid (m_axis.tvalid),
        .out_ready (m_axis.tready)
    );

    assign sts_good_cntr  = good_q;
    assign sts_short_cntr = short_q;
    assign sts_long_cntr  = long_q;
    assign sts_state      = state_q;

endmodule

// File: tb/tb_axis_depacketizer.sv
// Directed and randomized bench for axis_depacketizer with a packet-level
// reference model and an output scoreboard.
module tb_axis_depacketizer;
    import axis_depacketizer_pkg::*;

    localparam int W  = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic [CW-1:0] cfg_data = '0;
    logic [CW-1:0] sts_good, sts_short, sts_long;
    logic [1:0]    sts_state;

    axis_depacketizer_if #(.DATA_W(W)) s_if ();
    axis_depacketizer_if #(.DATA_W(W)) m_if ();

    axis_depacketizer #(
        .AXIS_TDATA_WIDTH (W),
        .CNTR_WIDTH       (CW),
        .SYNC_ON_RESET    ("TRUE")
    ) dut (
        .aclk           (clk),
        .areset         (areset),
        .cfg_data       (cfg_data),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .sts_good_cntr  (sts_good),
        .sts_short_cntr (sts_short),
        .sts_long_cntr  (sts_long),
        .sts_state      (sts_state)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  act_q[$];
    logic [CW-1:0] exp_good = '0, exp_short = '0, exp_long = '0;
    bit            sync_pending = 1'b1;
    int            rdy_mode = 0;
    bit            occ_chk = 1'b0;
    int            occ = 0;
    bit            prev_stall = 1'b0;
    logic [W-1:0]  prev_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = ~m_if.tready;
                default: m_if.tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Output collection, hold-stability and occupancy checks, all at negedge.
    always @(negedge clk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_if.tvalid, 1);
                check("hold_data", m_if.tdata, prev_data);
            end
            if (occ_chk) begin
                if (!s_if.tready) check("ready_low_only_full", occ, 2);
                check("valid_when_held", m_if.tvalid, occ != 0);
                occ = occ + int'(s_if.tvalid && s_if.tready) - int'(m_if.tvalid && m_if.tready);
            end
            if (m_if.tvalid && m_if.tready) act_q.push_back(m_if.tdata);
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
        end
    end

    task automatic send_beat(input logic [W-1:0] d, input bit last, input bit rand_idle);
        int t = 0;
        if (rand_idle) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        s_if.tdata  = d;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (s_if.tready) break;
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $error("FAIL s_ready_timeout: observed 0 expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    // Packet-level model: L is cfg_data at the first beat; first packet after
    // reset is dropped; forwarded payload is the first min(n, L) beats.
    task automatic send_packet(input int n, input logic [W-1:0] base, input bit rnd,
                               input bit rand_idle, input bit chk_long,
                               input int chg_at, input logic [CW-1:0] chg_val);
        logic [W-1:0] beats[$];
        logic [W-1:0] d;
        logic [CW:0]  len = '0;
        bit           dropped = sync_pending;
        for (int i = 0; i < n; i++) begin
            if (i == chg_at) cfg_data = chg_val;
            if (i == 0) len = {1'b0, cfg_data} + 1;
            d = rnd ? W'($urandom) : base + W'(i);
            send_beat(d, i == n - 1, rand_idle);
            beats.push_back(d);
            if (chk_long && !dropped && (i + 1) >= len && i < n - 1) begin
                check("discard_state", sts_state, ST_DISCARD);
                check("discard_ready", s_if.tready, 1);
            end
        end
        if (chk_long) check("run_after_long", sts_state, ST_RUN);
        if (dropped) begin
            sync_pending = 1'b0;
        end else begin
            if (n == len)      exp_good++;
            else if (n < len)  exp_short++;
            else               exp_long++;
            for (int i = 0; i < n && i < len; i++) exp_q.push_back(beats[i]);
        end
    endtask

    task automatic drain_check(input string tag);
        int quiet = 0;
        int t = 0;
        while (quiet < 3 && t < 1000) begin
            @(negedge clk);
            t++;
            quiet = m_if.tvalid ? 0 : quiet + 1;
        end
        if (quiet < 3) begin
            checks++;
            errors++;
            $error("FAIL %s_drain_timeout: observed busy expected idle", tag);
        end
        check({tag, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            check({tag, "_data"}, act_q[i], exp_q[i]);
        check({tag, "_good"}, sts_good, exp_good);
        check({tag, "_short"}, sts_short, exp_short);
        check({tag, "_long"}, sts_long, exp_long);
        act_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;

        // Reset values
        #12;
        check("rst_m_valid", m_if.tvalid, 0);
        check("rst_m_data", m_if.tdata, 0);
        check("rst_s_ready", s_if.tready, 0);
        check("rst_good", sts_good, 0);
        check("rst_short", sts_short, 0);
        check("rst_long", sts_long, 0);
        check("rst_state", sts_state, ST_SYNC);
        @(posedge clk);
        #3 areset = 1'b0;
        @(posedge clk);
        #1;
        check("sync_after_release", sts_state, ST_SYNC);

        // 1: sync discard then one good packet
        cfg_data = 3;
        send_packet(2, 32'hA, 0, 0, 0, -1, '0);
        check("run_after_sync", sts_state, ST_RUN);
        send_packet(4, 32'd1, 0, 0, 0, -1, '0);
        drain_check("t1");

        // 2: short then good
        send_packet(3, 32'd5, 0, 0, 0, -1, '0);
        send_packet(4, 32'd8, 0, 0, 0, -1, '0);
        drain_check("t2");

        // 3: long packet truncated
        send_packet(6, 32'd1, 0, 0, 1, -1, '0);
        drain_check("t3");

        // 4: alternating backpressure, continuous input
        cfg_data = 7;
        rdy_mode = 1;
        occ = 0;
        occ_chk = 1'b1;
        for (int p = 0; p < 4; p++) send_packet(8, '0, 1, 0, 0, -1, '0);
        drain_check("t4");
        occ_chk = 1'b0;
        rdy_mode = 0;

        // 5: asynchronous reset mid-packet
        cfg_data = 3;
        send_beat(32'h51, 0, 0);
        send_beat(32'h52, 0, 0);
        #2 areset = 1'b1;
        #1;
        check("arst_m_valid", m_if.tvalid, 0);
        check("arst_good", sts_good, 0);
        check("arst_short", sts_short, 0);
        check("arst_long", sts_long, 0);
        check("arst_state", sts_state, ST_SYNC);
        check("arst_s_ready", s_if.tready, 0);
        @(posedge clk);
        @(posedge clk);
        #3 areset = 1'b0;
        @(posedge clk);
        #1;
        act_q.delete();
        exp_q.delete();
        exp_good = '0;
        exp_short = '0;
        exp_long = '0;
        sync_pending = 1'b1;
        check("arst_resync_state", sts_state, ST_SYNC);
        send_packet(2, 32'h53, 0, 0, 0, -1, '0);
        check("arst_run_after_tlast", sts_state, ST_RUN);
        send_packet(4, 32'h61, 0, 0, 0, -1, '0);
        drain_check("t5");

        // 6: cfg_data change mid-packet only affects the next packet
        cfg_data = 3;
        send_packet(4, 32'h10, 0, 0, 0, 2, 32'd1);
        send_packet(2, 32'h20, 0, 0, 0, -1, '0);
        send_packet(4, 32'h30, 0, 0, 1, -1, '0);
        drain_check("t6");

        // Boundaries: single-beat good with len 0, all-ones length
        cfg_data = 0;
        send_packet(1, 32'h55, 0, 0, 0, -1, '0);
        check("latency_valid", m_if.tvalid, 1);
        check("latency_data", m_if.tdata, 32'h55);
        cfg_data = '1;
        send_packet(3, 32'h70, 0, 0, 0, -1, '0);
        drain_check("bnd");

        // Randomized traffic
        rdy_mode = 2;
        for (int p = 0; p < 25; p++) begin
            cfg_data = CW'($urandom_range(0, 5));
            send_packet($urandom_range(1, 8), '0, 1, 1, 0, -1, '0);
        end
        drain_check("rnd");
        rdy_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_depacketizer.md
Name: axis_depacketizer

Overview:
Receive-side counterpart of the AXIS packetizer. It consumes framed AXI4-Stream packets (tlast on the final beat) and checks each packet length against cfg_data+1 beats. It forwards payload as a continuous, unframed stream and counts good, short and long packets. It sits between a framed transport (DMA or link receive path) and sample-consuming DSP or FIFO blocks, and has a registered output stage for timing isolation.

Parameters:
AXIS_TDATA_WIDTH, 32, data width in bits.
CNTR_WIDTH, 32, width of cfg_data, the beat counter and the status counters.
SYNC_ON_RESET, "TRUE", "TRUE": leave reset in SYNC and discard until the first tlast; "FALSE": leave reset in RUN.

Ports:
aclk  in  1  clock.
areset  in  1  asynchronous, active-high reset.
cfg_data  in  CNTR_WIDTH  expected packet length minus one (L = cfg_data+1 beats).
s_axis_tready  out  1  input ready.
s_axis_tdata  in  AXIS_TDATA_WIDTH  input data.
s_axis_tvalid  in  1  input valid.
s_axis_tlast  in  1  input end of packet.
m_axis_tready  in  1  output ready.
m_axis_tdata  out  AXIS_TDATA_WIDTH  payload data, registered.
m_axis_tvalid  out  1  payload valid, registered.
sts_good_cntr  out  CNTR_WIDTH  packets of exactly L beats.
sts_short_cntr  out  CNTR_WIDTH  packets ending before L beats.
sts_long_cntr  out  CNTR_WIDTH  packets exceeding L beats.
sts_state  out  2  current FSM state encoding.

Behaviour:
- Reset (async assert, sync release): m_axis_tvalid=0, m_axis_tdata=0, all counters 0, beat counter 0, s_axis_tready=0, state=SYNC (or RUN if SYNC_ON_RESET="FALSE").
- Input handshake: an input beat transfers when s_axis_tvalid & s_axis_tready.
- Beat counter int_cntr (CNTR_WIDTH bits) holds the index of the next beat within the current packet.
- Latched length:
  - int_len_reg <= cfg_data on the first beat of each packet (int_cntr==0) in RUN.
  - All checks compare int_cntr against int_len_reg; a cfg_data change mid-packet affects only the next packet.
  - No +1 arithmetic is used, so cfg_data = all-ones is legal.
- States:
  - SYNC (0): s_axis_tready=1; beats are discarded. Beat with tlast -> RUN, int_cntr=0.
  - RUN (1): s_axis_tready = output buffer not full. Every accepted beat enters the output buffer. Per accepted beat:
    - tlast & int_cntr==len: good++, int_cntr=0.
    - tlast & int_cntr<len: short++, int_cntr=0.
    - ~tlast & int_cntr==len: beat is forwarded (it is beat L), long++, -> DISCARD.
    - otherwise: int_cntr++.
  - DISCARD (2): s_axis_tready=1; beats are discarded. Beat with tlast -> RUN, int_cntr=0.
- Short packets are forwarded in full; already-forwarded beats are never retracted. Long packets are truncated to L beats.
- Output stage is a 2-entry skid buffer:
  - Latency is 1 cycle from input acceptance to m_axis_tvalid.
  - Sustains 1 beat/cycle with m_axis_tready=1.
  - s_axis_tready in RUN deasserts only when both entries are full; it is a registered-friendly function of buffer occupancy and does not combinationally depend on m_axis_tready.
  - Order is preserved, with no loss and no duplication.
  - m_axis_tdata is held stable while tvalid=1 and tready=0.
- Counters wrap modulo 2^CNTR_WIDTH and update the cycle after the classifying beat.
- A single beat with tlast while int_cntr==0 and len==0 counts as good.
- areset mid-packet: buffered beats are lost, outputs return immediately to reset values, and the FSM resyncs per SYNC_ON_RESET.

Decomposition:
- Package axis_depacketizer_pkg:
  - State encoding constants ST_SYNC=2'd0, ST_RUN=2'd1, ST_DISCARD=2'd2.
  - Skid depth constant = 2.
- Sub-module axis_skid_buffer (width-parameterised, 2 entries, same async active-high reset) provides the output stage.
- FSM, beat counter and status counters live in the top level.

Test Plan:
1. SYNC_ON_RESET="TRUE", cfg_data=3; send beats A,B(tlast) then 1,2,3,4(tlast) -> output exactly 1,2,3,4; good=1, short=0, long=0; sts_state SYNC->RUN after B.
2. cfg_data=3; packet 5,6,7(tlast) then 8,9,10,11(tlast) -> all 7 beats forwarded in order; short=1, good=1.
3. cfg_data=3; packet 1..6 with tlast on 6 -> output 1,2,3,4; long=1; DISCARD during beats 5-6; s_axis_tready=1 in DISCARD; RUN after beat 6.
4. cfg_data=7; continuous valid, m_axis_tready pattern 1,0,1,0,... over 32 beats -> output sequence identical to input, no gaps beyond backpressure; s_axis_tready low only when 2 entries are held; good=4.
5. areset asserted asynchronously (mid-cycle) after beat 2 of a 4-beat packet -> m_axis_tvalid=0 and counters=0 before the next edge; after release, state=SYNC and the remainder of the packet up to its tlast is discarded.
6. cfg_data changed 3->1 at beat 2 of a 4-beat packet -> that packet counted good (good=1); next 2-beat packet counted good (good=2); a following 4-beat packet -> 2 beats forwarded, long=1.
